store_merge_unit: RTL and testbench
===================================

# store_merge_unit

Sits directly upstream of the 64-bit core memory model and turns sub-word store requests (byte, half, word, doubleword) into full 64-bit read-modify-write sequences. The memory only accepts whole aligned 64-bit writes, so sub-word stores are merged into the current word before being written back. Requests arrive from the core's store path over a valid/ready handshake. One response (with exception flag) is returned per request.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, memory word width; only 64 is supported
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_req_valid  in  1  store request valid
- out_req_ready  out  1  unit can accept a request
- in_req_address  in  ADDR_W  byte address of the store
- in_req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = doubleword
- in_req_data  in  DATA_W  store data, right-justified (bits [8·n−1:0] are used)
- out_resp_valid  out  1  response valid
- in_resp_ready  in  1  consumer accepts the response
- out_resp_exception  out  1  store failed (misaligned, read fault or write fault)
- out_mem_read_address  out  ADDR_W  word-aligned read address to memory
- in_mem_read_data  in  DATA_W  combinational read data from memory
- in_mem_read_exception  in  1  read fault for out_mem_read_address
- out_mem_write_enable  out  1  one-cycle write strobe
- out_mem_write_address  out  ADDR_W  word-aligned write address
- out_mem_write_data  out  DATA_W  merged 64-bit word
- in_mem_write_exception  in  1  write fault for out_mem_write_address

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- **IDLE**
  - out_req_ready = 1.
  - On in_req_valid, capture address, size and data.
  - Misaligned requests (address[2:0] mod 2^size ≠ 0) go to RESP with exception = 1. No memory access is made.
  - All other requests go to READ.
- **READ**
  - out_mem_read_address = {address[ADDR_W-1:3], 3'b0}.
  - Register in_mem_read_data and in_mem_read_exception.
  - On a read exception, go to RESP with exception = 1 and no write. Otherwise go to WRITE.
- **WRITE**
  - out_mem_write_enable = 1 for exactly one cycle, to the word address.
  - Byte mask = (2^(2^size) − 1) bytes, shifted left by address[2:0].
  - Merged data = (old & ~mask) | ((data << 8·address[2:0]) & mask).
  - Sample in_mem_write_exception in the same cycle, then go to RESP.
- **RESP**
  - Hold out_resp_valid and out_resp_exception stable until in_resp_ready.
  - Then go to IDLE.
- Only one request is outstanding at a time. out_req_ready = (state == IDLE).
- out_mem_read_address and out_mem_write_address are 0 outside READ and WRITE respectively. out_mem_write_data is 0 when the write enable is low.

## Timing
- Reset values: state IDLE, out_req_ready = 1 (the cycle after reset), all other outputs 0.
- The captured request registers reset to 0.
- Aligned sub-word request accepted in cycle T:
  - READ in T+1
  - write strobe in T+2
  - out_resp_valid first high in T+3
- Misaligned request accepted in cycle T: out_resp_valid in T+1.
- Reset asserted in any state returns the FSM to IDLE on the next edge. Any pending write strobe is dropped and no response is produced.
- in_resp_ready asserted the same cycle out_resp_valid rises completes the handshake. out_req_ready rises in the next cycle (no same-cycle bypass).
- in_req_valid is ignored outside IDLE.

## Configuration
- STORE_MERGE_FAST_DWORD_EN
  - **Defined:** aligned doubleword requests (size 3, address[2:0] = 0) skip READ. The write happens in T+1 and the response in T+2.
  - **Undefined:** all non-faulting requests take the READ path, giving uniform T+3 latency.

## Structure
- Package store_merge_pkg holds:
  - the store-size enum (BYTE, HALF, WORD, DWORD)
  - the FSM state enum
  - the byte-mask function from size and offset
- One sub-module, store_merge_datapath, holds the combinational mask and merge. The FSM and registers stay in store_merge_unit.

## Test plan
- **Byte store:** memory word at 0x100 = 0x1122334455667788; store byte 0xAB to 0x103. Write data = 0x11223344AB667788, write address = 0x100, response at T+3 with exception = 0.
- **Misaligned half:** half store to 0x101. Response at T+1 with exception = 1 and no write strobe observed.
- **Read fault:** in_mem_read_exception = 1 during READ for a word store to 0x200. Exception response and no write strobe.
- **Back-pressure:** hold in_resp_ready = 0 for 5 cycles. out_resp_valid and out_resp_exception stay stable, out_req_ready stays 0, and a new in_req_valid is ignored.
- **Mid-operation reset:** assert reset in the READ cycle. Next cycle is IDLE, out_req_ready = 1, no write strobe and no response.
- **Doubleword store:** store 0xDEADBEEFCAFEF00D to 0x08.
  - With STORE_MERGE_FAST_DWORD_EN: write in T+1, response in T+2.
  - Without it: write in T+2, response in T+3.
  - Write data equals the store data in both cases.

Source files
------------

// File: rtl/store_merge_pkg.sv
// Shared types and helpers for the store merge unit: store sizes, FSM states,
// the byte-lane mask and the alignment check.
package store_merge_pkg;

    typedef enum logic [1:0] {
        BYTE  = 2'd0,
        HALF  = 2'd1,
        WORD  = 2'd2,
        DWORD = 2'd3
    } store_size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Byte lanes touched by a store of the given size at the given offset.
    function automatic logic [7:0] byte_mask(input store_size_e size, input logic [2:0] offset);
        logic [7:0] base;
        case (size)
            BYTE:    base = 8'h01;
            HALF:    base = 8'h03;
            WORD:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << offset;
    endfunction

    function automatic logic is_misaligned(input store_size_e size, input logic [2:0] offset);
        logic mis;
        case (size)
            BYTE:    mis = 1'b0;
            HALF:    mis = offset[0];
            WORD:    mis = |offset[1:0];
            default: mis = |offset;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/store_merge_datapath.sv
// Combinational byte-lane merge of right-justified store data into an old
// 64-bit memory word.
module store_merge_datapath
    import store_merge_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  store_size_e       size_i,
    input  logic [2:0]        offset_i,
    input  logic [DATA_W-1:0] old_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] merged_o
);

    logic [7:0]        bmask;
    logic [DATA_W-1:0] bitmask;
    logic [DATA_W-1:0] shifted;

    assign bmask   = byte_mask(size_i, offset_i);
    assign shifted = data_i << {offset_i, 3'b000};

    always_comb begin
        bitmask = '0;
        for (int b = 0; b < DATA_W / 8; b++) begin
            bitmask[b*8 +: 8] = {8{bmask[b]}};
        end
    end

    assign merged_o = (old_i & ~bitmask) | (shifted & bitmask);

endmodule

// File: rtl/store_merge_unit.sv
// Sub-word store to 64-bit read-modify-write sequencer, one request at a time.
// Optional STORE_MERGE_FAST_DWORD_EN lets aligned doubleword stores skip the read.
module store_merge_unit
    import store_merge_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_req_valid,
    output logic              out_req_ready,
    input  logic [ADDR_W-1:0] in_req_address,
    input  logic [1:0]        in_req_size,
    input  logic [DATA_W-1:0] in_req_data,
    output logic              out_resp_valid,
    input  logic              in_resp_ready,
    output logic              out_resp_exception,
    output logic [ADDR_W-1:0] out_mem_read_address,
    input  logic [DATA_W-1:0] in_mem_read_data,
    input  logic              in_mem_read_exception,
    output logic              out_mem_write_enable,
    output logic [ADDR_W-1:0] out_mem_write_address,
    output logic [DATA_W-1:0] out_mem_write_data,
    input  logic              in_mem_write_exception
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    store_size_e       size_q, size_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] old_q, old_d;
    logic              exc_q, exc_d;
    logic [DATA_W-1:0] merged;
    logic [ADDR_W-1:0] word_addr;
    store_size_e       req_size;

    assign word_addr = {addr_q[ADDR_W-1:3], 3'b000};
    assign req_size  = store_size_e'(in_req_size);

    store_merge_datapath #(.DATA_W(DATA_W)) u_datapath (
        .size_i   (size_q),
        .offset_i (addr_q[2:0]),
        .old_i    (old_q),
        .data_i   (data_q),
        .merged_o (merged)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= BYTE;
            data_q  <= '0;
            old_q   <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            data_q  <= data_d;
            old_q   <= old_d;
            exc_q   <= exc_d;
        end
    end

    always_comb begin
        state_d               = state_q;
        addr_d                = addr_q;
        size_d                = size_q;
        data_d                = data_q;
        old_d                 = old_q;
        exc_d                 = exc_q;
        out_req_ready         = 1'b0;
        out_resp_valid        = 1'b0;
        out_resp_exception    = 1'b0;
        out_mem_read_address  = '0;
        out_mem_write_enable  = 1'b0;
        out_mem_write_address = '0;
        out_mem_write_data    = '0;

        case (state_q)
            IDLE: begin
                out_req_ready = 1'b1;
                if (in_req_valid) begin
                    addr_d = in_req_address;
                    size_d = req_size;
                    data_d = in_req_data;
                    exc_d  = 1'b0;
                    if (is_misaligned(req_size, in_req_address[2:0])) begin
                        exc_d   = 1'b1;
                        state_d = RESP;
                    end else begin
`ifdef STORE_MERGE_FAST_DWORD_EN
                        // A full-word store overwrites every lane, so the old word is irrelevant.
                        state_d = (req_size == DWORD) ? WRITE : READ;
`else
                        state_d = READ;
`endif
                    end
                end
            end
            READ: begin
                out_mem_read_address = word_addr;
                old_d                = in_mem_read_data;
                if (in_mem_read_exception) begin
                    exc_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                out_mem_write_enable  = 1'b1;
                out_mem_write_address = word_addr;
                out_mem_write_data    = merged;
                exc_d                 = in_mem_write_exception;
                state_d               = RESP;
            end
            RESP: begin
                out_resp_valid     = 1'b1;
                out_resp_exception = exc_q;
                if (in_resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_store_merge_unit.sv
// Self-checking bench for store_merge_unit: directed cases plus random stores
// against a byte-level memory reference model.
module tb_store_merge_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_req_valid;
    logic        out_req_ready;
    logic [63:0] in_req_address;
    logic [1:0]  in_req_size;
    logic [63:0] in_req_data;
    logic        out_resp_valid;
    logic        in_resp_ready;
    logic        out_resp_exception;
    logic [63:0] out_mem_read_address;
    logic [63:0] in_mem_read_data;
    logic        in_mem_read_exception;
    logic        out_mem_write_enable;
    logic [63:0] out_mem_write_address;
    logic [63:0] out_mem_write_data;
    logic        in_mem_write_exception;

    logic [63:0] mem [128];
    logic [63:0] last_wd;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    assign in_mem_read_data = mem[out_mem_read_address[9:3]];

    store_merge_unit #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .in_req_valid           (in_req_valid),
        .out_req_ready          (out_req_ready),
        .in_req_address         (in_req_address),
        .in_req_size            (in_req_size),
        .in_req_data            (in_req_data),
        .out_resp_valid         (out_resp_valid),
        .in_resp_ready          (in_resp_ready),
        .out_resp_exception     (out_resp_exception),
        .out_mem_read_address   (out_mem_read_address),
        .in_mem_read_data       (in_mem_read_data),
        .in_mem_read_exception  (in_mem_read_exception),
        .out_mem_write_enable   (out_mem_write_enable),
        .out_mem_write_address  (out_mem_write_address),
        .out_mem_write_data     (out_mem_write_data),
        .in_mem_write_exception (in_mem_write_exception)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One store transaction; the expected schedule comes from the operation rules.
    task automatic run_store(input logic [63:0] a, input logic [1:0] sz, input logic [63:0] d,
                             input logic rf, input logic wf, input int bp);
        int          nbytes, off, wr_c, rd_c, resp_c, writes;
        logic        mis, fast, exc_exp;
        logic [63:0] exp_word;
        nbytes   = 1 << sz;
        off      = int'(a % 8);
        mis      = (off % nbytes) != 0;
        exp_word = mem[a[9:3]];
        for (int b = 0; b < nbytes; b++) exp_word[(off+b)*8 +: 8] = d[b*8 +: 8];
`ifdef STORE_MERGE_FAST_DWORD_EN
        fast = (sz == 2'd3) && !mis;
`else
        fast = 1'b0;
`endif
        if (mis)       begin rd_c = -1; wr_c = -1; resp_c = 1; exc_exp = 1'b1; end
        else if (fast) begin rd_c = -1; wr_c = 1;  resp_c = 2; exc_exp = wf;   end
        else if (rf)   begin rd_c = 1;  wr_c = -1; resp_c = 2; exc_exp = 1'b1; end
        else           begin rd_c = 1;  wr_c = 2;  resp_c = 3; exc_exp = wf;   end
        writes = 0;

        @(negedge clk);
        chk("req_ready_idle", out_req_ready, 1'b1);
        in_req_valid           = 1'b1;
        in_req_address         = a;
        in_req_size            = sz;
        in_req_data            = d;
        in_mem_read_exception  = rf;
        in_mem_write_exception = wf;
        for (int c = 1; c <= resp_c; c++) begin
            @(negedge clk);
            if (c == 1) in_req_valid = 1'b0;
            chk("req_ready_busy", out_req_ready, 1'b0);
            chk("read_addr", out_mem_read_address, (c == rd_c) ? {a[63:3], 3'b000} : 64'd0);
            chk("write_en", out_mem_write_enable, (c == wr_c) ? 1'b1 : 1'b0);
            if (out_mem_write_enable) begin
                writes++;
                last_wd = out_mem_write_data;
                chk("write_addr", out_mem_write_address, {a[63:3], 3'b000});
                chk("write_data", out_mem_write_data, exp_word);
            end else begin
                chk("write_data_idle", out_mem_write_data, 64'd0);
            end
            chk("resp_valid", out_resp_valid, (c == resp_c) ? 1'b1 : 1'b0);
        end
        chk("resp_exc", out_resp_exception, exc_exp);
        if (wr_c > 0 && !wf) mem[a[9:3]] = exp_word;

        for (int i = 0; i < bp; i++) begin
            in_resp_ready  = 1'b0;
            in_req_valid   = 1'b1;
            in_req_address = 64'($urandom_range(0, 1023));
            in_req_size    = 2'($urandom_range(0, 3));
            @(negedge clk);
            chk("bp_resp_valid", out_resp_valid, 1'b1);
            chk("bp_resp_exc", out_resp_exception, exc_exp);
            chk("bp_req_ready", out_req_ready, 1'b0);
            chk("bp_write_en", out_mem_write_enable, 1'b0);
        end
        in_req_valid  = 1'b0;
        in_resp_ready = 1'b1;
        @(negedge clk);
        in_resp_ready = 1'b0;
        chk("post_resp_valid", out_resp_valid, 1'b0);
        chk("post_req_ready", out_req_ready, 1'b1);
        chk("write_count", 64'(writes), (wr_c > 0) ? 64'd1 : 64'd0);
    endtask

    initial begin
        reset                  = 1'b1;
        in_req_valid           = 1'b0;
        in_req_address         = '0;
        in_req_size            = '0;
        in_req_data            = '0;
        in_resp_ready          = 1'b0;
        in_mem_read_exception  = 1'b0;
        in_mem_write_exception = 1'b0;
        last_wd                = '0;
        for (int i = 0; i < 128; i++) mem[i] = {$urandom, $urandom};
        mem[8'h20] = 64'h1122334455667788;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", out_req_ready, 1'b1);
        chk("rst_resp_valid", out_resp_valid, 1'b0);
        chk("rst_resp_exc", out_resp_exception, 1'b0);
        chk("rst_write_en", out_mem_write_enable, 1'b0);
        chk("rst_read_addr", out_mem_read_address, 64'd0);

        // Byte store into a known word
        run_store(64'h103, 2'd0, 64'h00000000000000AB, 1'b0, 1'b0, 0);
        chk("byte_merge_const", last_wd, 64'h11223344AB667788);
        // Misaligned half
        run_store(64'h101, 2'd1, 64'h000000000000BEEF, 1'b0, 1'b0, 0);
        // Read fault
        run_store(64'h200, 2'd2, 64'h0000000012345678, 1'b1, 1'b0, 0);
        // Write fault
        run_store(64'h2A4, 2'd2, 64'h00000000CAFEBABE, 1'b0, 1'b1, 0);
        // Back-pressure
        run_store(64'h040, 2'd1, 64'h0000000000005A5A, 1'b0, 1'b0, 5);
        // Doubleword
        run_store(64'h008, 2'd3, 64'hDEADBEEFCAFEF00D, 1'b0, 1'b0, 0);
        chk("dword_data_const", last_wd, 64'hDEADBEEFCAFEF00D);

        // Reset during READ drops the operation
        @(negedge clk);
        in_req_valid   = 1'b1;
        in_req_address = 64'h0F0;
        in_req_size    = 2'd2;
        in_req_data    = 64'h0000000077778888;
        @(negedge clk);
        in_req_valid = 1'b0;
        chk("mr_in_read", out_mem_read_address, 64'h0F0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mr_req_ready", out_req_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("mr_write_en", out_mem_write_enable, 1'b0);
            chk("mr_resp_valid", out_resp_valid, 1'b0);
            @(negedge clk);
        end

        for (int t = 0; t < 40; t++) begin
            run_store(64'($urandom_range(0, 1023)), 2'($urandom_range(0, 3)),
                      {$urandom, $urandom}, ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 7) == 0), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
